// File: rtl/kf_pkg.sv
// Shared Kalman-filter datapath definitions: default widths, arbiter FSM
// encoding and the requester-index width helper.
package kf_pkg;

  localparam int KF_W    = 24;
  localparam int KF_FRAC = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } inv_state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inv_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from ptr+1, wrapping modulo N.
module inv_rr_pick
  import kf_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic found;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/inverse_arbiter.sv
// Shares one reciprocal divider among N signed requesters: round-robin grant,
// sign/magnitude conditioning, start/rdy sequencing, tagged result with watchdog.
module inverse_arbiter
  import kf_pkg::*;
#(
  parameter int W    = KF_W,
  parameter int FRAC = KF_FRAC,
  parameter int N    = 4,
  parameter int TMO  = 72,
  parameter int IDW  = idw(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      req_den,
  output logic [N-1:0]        ack,
  output logic                resp_valid,
  output logic [IDW-1:0]      resp_id,
  output logic signed [W-1:0] resp_q,
  output logic                resp_err,
  output logic                div_start,
  output logic [W-2:0]        div_den_mag,
  input  logic [W-2:0]        div_q_mag,
  input  logic                div_rdy
);

  localparam int WDW = $clog2(TMO + 1);
  localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  if (N < 2 || N > 8 || FRAC >= W || TMO < 2) begin : g_bad_cfg
    $error("inverse_arbiter: unsupported parameter set");
  end

  // Zero clamps to 1 and the most-negative value saturates, so the divider
  // never sees a zero or an unrepresentable magnitude.
  function automatic logic [W-2:0] mag_of(input logic signed [W-1:0] d);
    logic signed [W-1:0] a;
    a = d[W-1] ? -d : d;
    if (d == '0)
      return {{(W-2){1'b0}}, 1'b1};
    else if (d == MOST_NEG)
      return '1;
    return a[W-2:0];
  endfunction

  function automatic logic signed [W-1:0] apply_sign(input logic s,
                                                     input logic [W-2:0] q);
    logic signed [W-1:0] u;
    u = {1'b0, q};
    return s ? -u : u;
  endfunction

  inv_state_t          state, state_nx;
  logic [IDW-1:0]      ptr, id_r, pick_idx;
  logic                pick_any, sign_r;
  logic [WDW-1:0]      wd;
  logic signed [W-1:0] den_arr [N];
  logic                accept, expire;

  inv_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < N; i++) den_arr[i] = req_den[i*W +: W];
  end

  // First WAIT cycle (wd == 0) masks a div_rdy left over from the last operation.
  assign accept = (state == ST_WAIT) && (wd != '0) && div_rdy;
  assign expire = (state == ST_WAIT) && !accept && (wd == WDW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (accept || expire) state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Registered outputs and transaction context, updated by the same edges as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack         <= '0;
      div_start   <= 1'b0;
      div_den_mag <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_q      <= '0;
      resp_err    <= 1'b0;
      ptr         <= IDW'(N - 1);
      id_r        <= '0;
      sign_r      <= 1'b0;
      wd          <= '0;
    end else begin
      ack        <= '0;
      div_start  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            ack         <= N'(1) << pick_idx;
            div_start   <= 1'b1;
            div_den_mag <= mag_of(den_arr[pick_idx]);
            sign_r      <= den_arr[pick_idx][W-1];
            id_r        <= pick_idx;
            ptr         <= pick_idx;
          end
        end
        ST_ISSUE: wd <= '0;
        ST_WAIT: begin
          if (accept) begin
            resp_valid <= 1'b1;
            resp_id    <= id_r;
            resp_q     <= apply_sign(sign_r, div_q_mag);
          end else if (expire) begin
            resp_valid <= 1'b1;
            resp_id    <= id_r;
            resp_q     <= '0;
            resp_err   <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
